or1k_ifetch_bus_arb: RTL and testbench
======================================

Name: or1k_ifetch_bus_arb

Overview:
- Single-master instruction bus port shared by two fetch-side requesters:
  - ITLB hardware reload walker, driven by the IMMU `tlb_reload_*` handshake.
  - Instruction-cache line refill.
- Serialises single-word PTE reads and wrapping line bursts onto one bus, and returns data, acks and errors to the owning requester.
- Sits between the IMMU/icache and the instruction bus bridge.

Parameters:
- OPTION_OPERAND_WIDTH, 32: address and data width.
- OPTION_ICACHE_BLOCK_WIDTH, 5: log2 of line bytes. Burst length BW = 2^(OPTION_ICACHE_BLOCK_WIDTH-2) words (8 at default).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- tlb_reload_req_i  in  1  walker request, held across PTE-pointer and PTE reads.
- tlb_reload_addr_i  in  32  walker word address; may change the cycle after each ack.
- tlb_reload_ack_o  out  1  one-cycle pulse per completed walker read.
- tlb_reload_data_o  out  32  read data, valid with tlb_reload_ack_o.
- tlb_reload_err_o  out  1  one-cycle pulse on bus error during a walker read.
- refill_req_i  in  1  icache refill request.
- refill_adr_i  in  32  critical-word address.
- refill_ack_o  out  1  pulse per refill word.
- refill_dat_o  out  32  refill data, valid with refill_ack_o.
- refill_last_o  out  1  high with the final refill_ack_o of a line.
- refill_err_o  out  1  one-cycle pulse on bus error during a refill.
- ibus_req_o  out  1  bus request.
- ibus_adr_o  out  32  bus word address.
- ibus_burst_o  out  1  high while more burst words follow the current one.
- ibus_ack_i  in  1  bus data ack.
- ibus_err_i  in  1  bus error; takes precedence over ibus_ack_i.
- ibus_dat_i  in  32  bus read data.

Behaviour:
- Reset, rst=0, any time including mid-transfer:
  - state IDLE, all outputs 0, beat counter 0.
  - An in-flight transfer is dropped; no ack or err is emitted.
- States: IDLE, TLB, TLB_GAP, REFILL.
- IDLE:
  - tlb_reload_req_i has priority: latch tlb_reload_addr_i into ibus_adr_o, go to TLB.
  - Else refill_req_i: latch refill_adr_i, clear counter, go to REFILL.
  - ibus_req_o rises the cycle after the request is sampled (1-cycle grant latency).
  - Both requests high in the same cycle -> TLB wins; refill is served afterwards.
- TLB:
  - ibus_req_o=1, ibus_burst_o=0.
  - On ibus_ack_i: tlb_reload_data_o<=ibus_dat_i, tlb_reload_ack_o pulses 1 cycle, ibus_req_o<=0, go to TLB_GAP.
- TLB_GAP:
  - One idle cycle so the walker can present its next address.
  - If tlb_reload_req_i=1: re-latch tlb_reload_addr_i, go to TLB.
  - Else go to IDLE.
- REFILL:
  - ibus_req_o=1.
  - ibus_burst_o=1 unless the beat counter equals BW-1.
  - On each ibus_ack_i: refill_dat_o<=ibus_dat_i, refill_ack_o pulses.
  - On each ibus_ack_i: address word-index bits [OPTION_ICACHE_BLOCK_WIDTH-1:2] increment modulo BW. Upper bits are unchanged, giving critical-word-first wrap. Counter increments.
  - On ack with counter=BW-1: refill_last_o=1 with that ack, ibus_req_o<=0, go to IDLE.
  - refill_req_i falling mid-burst: the current beat completes (ack not forwarded), then IDLE. refill_last_o is not raised.
  - tlb_reload_req_i asserting mid-burst: waits; a refill is never pre-empted.
- Errors:
  - ibus_err_i in TLB or REFILL -> owner's err output pulses 1 cycle, no ack for that beat, ibus_req_o<=0, go to IDLE.
  - ibus_err_i and ibus_ack_i both high -> treated as error only.
- ibus_ack_i/ibus_err_i while ibus_req_o=0 -> ignored.
- At most one of tlb_reload_ack_o, refill_ack_o, tlb_reload_err_o, refill_err_o is high in any cycle.
- Back-to-back IDLE re-arbitration: 1 idle cycle minimum between owners.

Test Plan:
1. Walker read:
   - Stimulus: tlb_reload_req_i=1, addr 0x0010_0040; bus acks after 2 cycles with 0x0002_2000.
   - Required: ibus_adr_o=0x0010_0040, one tlb_reload_ack_o pulse, data=0x0002_2000, then TLB_GAP.
   - Stimulus: req still high, new addr 0x0002_2104.
   - Required: second read to 0x0002_2104; req low after second ack -> IDLE.
2. Wrapping refill:
   - Stimulus: refill_adr_i=0x0000_1018, zero-wait acks.
   - Required: addresses 0x1018, 0x101C, 0x1000 … 0x1014 (8 beats); ibus_burst_o low only on the 0x1014 beat; refill_last_o with the 8th ack.
3. Simultaneous requests:
   - Stimulus: both requests rise in the same cycle.
   - Required: TLB read completes first, then the refill starts after the gap. No overlapping acks.
4. Bus error:
   - Stimulus: ibus_err_i on refill beat 3.
   - Required: refill_err_o pulses once, no refill_last_o, ibus_req_o=0 next cycle, state IDLE.
   - Stimulus: ibus_err_i with ibus_ack_i on a walker read.
   - Required: tlb_reload_err_o only, no ack.
5. Reset mid-burst:
   - Stimulus: rst=0 asynchronously after beat 4.
   - Required: all outputs 0 immediately.
   - Stimulus: release rst with refill_req_i=1.
   - Required: fresh 8-beat burst from refill_adr_i.
6. Refill abort:
   - Stimulus: refill_req_i drops during beat 2.
   - Required: beat 2 completes without refill_ack_o, ibus_req_o falls, IDLE. A pending tlb_reload_req_i is granted on the next cycle.

Source files
------------

// File: rtl/or1k_ifetch_bus_arb.sv
// Instruction-side bus arbiter: serialises ITLB reload walker reads and wrapping
// icache line refills onto a single instruction bus master port.
module or1k_ifetch_bus_arb #(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            tlb_reload_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] tlb_reload_addr_i,
    output logic                            tlb_reload_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] tlb_reload_data_o,
    output logic                            tlb_reload_err_o,

    input  logic                            refill_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
    output logic                            refill_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] refill_dat_o,
    output logic                            refill_last_o,
    output logic                            refill_err_o,

    output logic                            ibus_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
    output logic                            ibus_burst_o,
    input  logic                            ibus_ack_i,
    input  logic                            ibus_err_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_dat_i
);

    localparam int IDX_HI = OPTION_ICACHE_BLOCK_WIDTH - 1;
    localparam int IDX_W  = OPTION_ICACHE_BLOCK_WIDTH - 2;
    localparam logic [IDX_W-1:0] LAST_BEAT = {IDX_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        TLB,
        TLB_GAP,
        REFILL
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] beat_cnt;

    // Pulse outputs default low every cycle; ibus_req_o is only high in TLB/REFILL,
    // so bus acks/errors arriving while idle or in the gap fall through unused.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            beat_cnt          <= '0;
            tlb_reload_ack_o  <= 1'b0;
            tlb_reload_data_o <= '0;
            tlb_reload_err_o  <= 1'b0;
            refill_ack_o      <= 1'b0;
            refill_dat_o      <= '0;
            refill_last_o     <= 1'b0;
            refill_err_o      <= 1'b0;
            ibus_req_o        <= 1'b0;
            ibus_adr_o        <= '0;
            ibus_burst_o      <= 1'b0;
        end else begin
            tlb_reload_ack_o <= 1'b0;
            tlb_reload_err_o <= 1'b0;
            refill_ack_o     <= 1'b0;
            refill_last_o    <= 1'b0;
            refill_err_o     <= 1'b0;

            case (state)
                IDLE: begin
                    if (tlb_reload_req_i) begin
                        ibus_adr_o   <= tlb_reload_addr_i;
                        ibus_req_o   <= 1'b1;
                        ibus_burst_o <= 1'b0;
                        state        <= TLB;
                    end else if (refill_req_i) begin
                        ibus_adr_o   <= refill_adr_i;
                        beat_cnt     <= '0;
                        ibus_req_o   <= 1'b1;
                        ibus_burst_o <= 1'b1;
                        state        <= REFILL;
                    end
                end

                TLB: begin
                    if (ibus_err_i) begin
                        tlb_reload_err_o <= 1'b1;
                        ibus_req_o       <= 1'b0;
                        state            <= IDLE;
                    end else if (ibus_ack_i) begin
                        tlb_reload_data_o <= ibus_dat_i;
                        tlb_reload_ack_o  <= 1'b1;
                        ibus_req_o        <= 1'b0;
                        state             <= TLB_GAP;
                    end
                end

                TLB_GAP: begin
                    if (tlb_reload_req_i) begin
                        ibus_adr_o <= tlb_reload_addr_i;
                        ibus_req_o <= 1'b1;
                        state      <= TLB;
                    end else begin
                        state <= IDLE;
                    end
                end

                REFILL: begin
                    if (ibus_err_i) begin
                        refill_err_o <= 1'b1;
                        ibus_req_o   <= 1'b0;
                        ibus_burst_o <= 1'b0;
                        state        <= IDLE;
                    end else if (ibus_ack_i) begin
                        if (!refill_req_i) begin
                            // Cache gave up on the line: finish the beat silently.
                            ibus_req_o   <= 1'b0;
                            ibus_burst_o <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            refill_dat_o           <= ibus_dat_i;
                            refill_ack_o           <= 1'b1;
                            ibus_adr_o[IDX_HI:2]   <= ibus_adr_o[IDX_HI:2] + IDX_W'(1);
                            beat_cnt               <= beat_cnt + IDX_W'(1);
                            if (beat_cnt == LAST_BEAT) begin
                                refill_last_o <= 1'b1;
                                ibus_req_o    <= 1'b0;
                                ibus_burst_o  <= 1'b0;
                                state         <= IDLE;
                            end else begin
                                ibus_burst_o <= (beat_cnt + IDX_W'(1)) != LAST_BEAT;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_or1k_ifetch_bus_arb.sv
// Self-checking bench for or1k_ifetch_bus_arb: directed scenarios plus randomized
// transactions compared against an address/data model of the wrapping bus protocol.
module tb_or1k_ifetch_bus_arb;

    localparam int BW = 8;
    localparam logic [31:0] IDX_MASK = 32'h0000_001C;
    localparam int EV_NONE  = 0;
    localparam int EV_ERR   = 1;
    localparam int EV_ABORT = 2;
    localparam int EV_RESET = 3;

    logic        clk;
    logic        rst;
    logic        tlb_reload_req_i;
    logic [31:0] tlb_reload_addr_i;
    logic        tlb_reload_ack_o;
    logic [31:0] tlb_reload_data_o;
    logic        tlb_reload_err_o;
    logic        refill_req_i;
    logic [31:0] refill_adr_i;
    logic        refill_ack_o;
    logic [31:0] refill_dat_o;
    logic        refill_last_o;
    logic        refill_err_o;
    logic        ibus_req_o;
    logic [31:0] ibus_adr_o;
    logic        ibus_burst_o;
    logic        ibus_ack_i;
    logic        ibus_err_i;
    logic [31:0] ibus_dat_i;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] key;

    or1k_ifetch_bus_arb dut (
        .clk               (clk),
        .rst               (rst),
        .tlb_reload_req_i  (tlb_reload_req_i),
        .tlb_reload_addr_i (tlb_reload_addr_i),
        .tlb_reload_ack_o  (tlb_reload_ack_o),
        .tlb_reload_data_o (tlb_reload_data_o),
        .tlb_reload_err_o  (tlb_reload_err_o),
        .refill_req_i      (refill_req_i),
        .refill_adr_i      (refill_adr_i),
        .refill_ack_o      (refill_ack_o),
        .refill_dat_o      (refill_dat_o),
        .refill_last_o     (refill_last_o),
        .refill_err_o      (refill_err_o),
        .ibus_req_o        (ibus_req_o),
        .ibus_adr_o        (ibus_adr_o),
        .ibus_burst_o      (ibus_burst_o),
        .ibus_ack_i        (ibus_ack_i),
        .ibus_err_i        (ibus_err_i),
        .ibus_dat_i        (ibus_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Bus slave memory contents: any fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ key ^ 32'h5A5A_0F0F;
    endfunction

    // Critical-word-first address for beat i: word index wraps inside the line.
    function automatic logic [31:0] wrap_adr(input logic [31:0] base, input int i);
        return (base & ~IDX_MASK) | ((base + 32'(4 * i)) & IDX_MASK);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (ibus_req_o !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk1(tag, ibus_req_o, 1'b1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk1("single_pulse",
                 $countones({tlb_reload_ack_o, tlb_reload_err_o, refill_ack_o, refill_err_o}) <= 1,
                 1'b1);
        end
    end

    task automatic walker_read(input logic [31:0] addr, input logic [31:0] data,
                               input bit with_err, input bit keep_req,
                               input logic [31:0] next_addr);
        int n;
        wait_req("tlb_grant");
        chk32("tlb_adr", ibus_adr_o, addr);
        chk1("tlb_burst", ibus_burst_o, 1'b0);
        n = $urandom_range(0, 2);
        repeat (n) begin
            tick();
            chk1("tlb_hold_req", ibus_req_o, 1'b1);
            chk1("tlb_early_ack", tlb_reload_ack_o, 1'b0);
        end
        ibus_dat_i = data;
        ibus_ack_i = 1'b1;
        ibus_err_i = with_err;
        tick();
        ibus_ack_i = 1'b0;
        ibus_err_i = 1'b0;
        chk1("tlb_ack", tlb_reload_ack_o, !with_err);
        chk1("tlb_err", tlb_reload_err_o, with_err);
        if (!with_err) chk32("tlb_data", tlb_reload_data_o, data);
        chk1("tlb_no_refill_ack", refill_ack_o, 1'b0);
        chk1("tlb_req_drop", ibus_req_o, 1'b0);
        if (keep_req && !with_err) tlb_reload_addr_i = next_addr;
        else tlb_reload_req_i = 1'b0;
    endtask

    task automatic refill_burst(input logic [31:0] base, input int ev_kind, input int ev_beat,
                                input bit raise_tlb, input logic [31:0] tlb_addr);
        for (int i = 0; i < BW; i++) begin
            logic [31:0] exp_adr;
            int n;
            exp_adr = wrap_adr(base, i);
            wait_req("refill_grant");
            chk32("refill_adr", ibus_adr_o, exp_adr);
            chk1("refill_burst", ibus_burst_o, i != BW - 1);
            if (raise_tlb && i == 0) begin
                tlb_reload_addr_i = tlb_addr;
                tlb_reload_req_i  = 1'b1;
            end
            if (ev_kind == EV_RESET && i == ev_beat) begin
                #2 rst = 1'b0;
                #1;
                chk1("rst_req", ibus_req_o, 1'b0);
                chk1("rst_burst", ibus_burst_o, 1'b0);
                chk32("rst_adr", ibus_adr_o, 32'h0);
                chk32("rst_pulses",
                      32'({tlb_reload_ack_o, tlb_reload_err_o, refill_ack_o, refill_last_o, refill_err_o}),
                      32'h0);
                chk32("rst_tlb_data", tlb_reload_data_o, 32'h0);
                chk32("rst_refill_dat", refill_dat_o, 32'h0);
                return;
            end
            if (ev_kind == EV_ABORT && i == ev_beat) refill_req_i = 1'b0;
            n = $urandom_range(0, 2);
            repeat (n) begin
                tick();
                chk1("refill_hold_req", ibus_req_o, 1'b1);
                chk1("refill_early_ack", refill_ack_o, 1'b0);
            end
            ibus_dat_i = mem_word(exp_adr);
            ibus_ack_i = 1'b1;
            ibus_err_i = (ev_kind == EV_ERR && i == ev_beat);
            tick();
            ibus_ack_i = 1'b0;
            ibus_err_i = 1'b0;
            if (ev_kind == EV_ERR && i == ev_beat) begin
                chk1("refill_err", refill_err_o, 1'b1);
                chk1("refill_err_no_ack", refill_ack_o, 1'b0);
                chk1("refill_err_no_last", refill_last_o, 1'b0);
                chk1("refill_err_req", ibus_req_o, 1'b0);
                refill_req_i = 1'b0;
                tick();
                chk1("refill_err_idle", ibus_req_o, 1'b0);
                chk1("refill_err_once", refill_err_o, 1'b0);
                return;
            end
            if (ev_kind == EV_ABORT && i == ev_beat) begin
                chk1("abort_no_ack", refill_ack_o, 1'b0);
                chk1("abort_no_last", refill_last_o, 1'b0);
                chk1("abort_req", ibus_req_o, 1'b0);
                return;
            end
            chk1("refill_ack", refill_ack_o, 1'b1);
            chk32("refill_dat", refill_dat_o, mem_word(exp_adr));
            chk1("refill_last", refill_last_o, i == BW - 1);
            chk1("refill_no_err", refill_err_o, 1'b0);
            chk1("refill_no_tlb_ack", tlb_reload_ack_o, 1'b0);
            if (i == BW - 1) begin
                chk1("refill_end_req", ibus_req_o, 1'b0);
                refill_req_i = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        key               = $urandom;
        rst               = 1'b0;
        tlb_reload_req_i  = 1'b0;
        tlb_reload_addr_i = '0;
        refill_req_i      = 1'b0;
        refill_adr_i      = '0;
        ibus_ack_i        = 1'b0;
        ibus_err_i        = 1'b0;
        ibus_dat_i        = '0;

        repeat (3) @(negedge clk);
        chk1("reset_req", ibus_req_o, 1'b0);
        chk32("reset_adr", ibus_adr_o, 32'h0);
        chk32("reset_pulses",
              32'({tlb_reload_ack_o, tlb_reload_err_o, refill_ack_o, refill_last_o, refill_err_o, ibus_burst_o}),
              32'h0);
        rst = 1'b1;
        tick();

        $display("[TB] stray bus acks while idle");
        ibus_ack_i = 1'b1;
        ibus_err_i = 1'b1;
        repeat (2) begin
            tick();
            chk32("idle_ignore",
                  32'({tlb_reload_ack_o, tlb_reload_err_o, refill_ack_o, refill_err_o, ibus_req_o}),
                  32'h0);
        end
        ibus_ack_i = 1'b0;
        ibus_err_i = 1'b0;

        $display("[TB] walker reads");
        tlb_reload_addr_i = 32'h0010_0040;
        tlb_reload_req_i  = 1'b1;
        tick();
        chk1("grant_latency", ibus_req_o, 1'b1);
        walker_read(32'h0010_0040, 32'h0002_2000, 1'b0, 1'b1, 32'h0002_2104);
        walker_read(32'h0002_2104, $urandom, 1'b0, 1'b0, 32'h0);

        $display("[TB] wrapping refill");
        refill_adr_i = 32'h0000_1018;
        refill_req_i = 1'b1;
        refill_burst(32'h0000_1018, EV_NONE, 0, 1'b0, 32'h0);

        $display("[TB] simultaneous requests");
        a = $urandom & 32'hFFFF_FFFC;
        b = $urandom & 32'hFFFF_FFFC;
        tlb_reload_addr_i = a;
        refill_adr_i      = b;
        tlb_reload_req_i  = 1'b1;
        refill_req_i      = 1'b1;
        walker_read(a, $urandom, 1'b0, 1'b0, 32'h0);
        refill_burst(b, EV_NONE, 0, 1'b0, 32'h0);

        $display("[TB] bus errors");
        b = $urandom & 32'hFFFF_FFFC;
        refill_adr_i = b;
        refill_req_i = 1'b1;
        refill_burst(b, EV_ERR, 2, 1'b0, 32'h0);
        a = $urandom & 32'hFFFF_FFFC;
        tlb_reload_addr_i = a;
        tlb_reload_req_i  = 1'b1;
        walker_read(a, $urandom, 1'b1, 1'b0, 32'h0);

        $display("[TB] reset mid-burst");
        b = $urandom & 32'hFFFF_FFFC;
        refill_adr_i = b;
        refill_req_i = 1'b1;
        refill_burst(b, EV_RESET, 4, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        refill_burst(b, EV_NONE, 0, 1'b0, 32'h0);

        $display("[TB] refill abort with pending walker");
        b = $urandom & 32'hFFFF_FFFC;
        a = $urandom & 32'hFFFF_FFFC;
        refill_adr_i = b;
        refill_req_i = 1'b1;
        refill_burst(b, EV_ABORT, 1, 1'b1, a);
        tick();
        chk1("abort_tlb_grant", ibus_req_o, 1'b1);
        chk32("abort_tlb_adr", ibus_adr_o, a);
        walker_read(a, $urandom, 1'b0, 1'b0, 32'h0);

        $display("[TB] random transactions");
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom & 32'hFFFF_FFFC;
                tlb_reload_addr_i = a;
                tlb_reload_req_i  = 1'b1;
                walker_read(a, $urandom, 1'b0, 1'b0, 32'h0);
            end else begin
                b = $urandom & 32'hFFFF_FFFC;
                refill_adr_i = b;
                refill_req_i = 1'b1;
                refill_burst(b, EV_NONE, 0, 1'b0, 32'h0);
            end
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
